// File: rtl/continuous_sensing_scheduler_if.sv
// Handshake bundle between the scheduler and its decoder, sensor driver and UART transmitter.
interface continuous_sensing_scheduler_if;
  logic       CMD_VALID;
  logic       CONTINUOUS_EN;
  logic       BREAK_CONTINUOUS;
  logic [1:0] DATA_TYPE;
  logic       SENSOR_START;
  logic       SENSOR_DONE;
  logic       SENSOR_ERROR;
  logic       TX_START;
  logic [1:0] TX_TYPE;
  logic       TX_ERR;
  logic       TX_DONE;
  logic       BUSY;
  logic       CONT_ACTIVE;
  logic [1:0] ACTIVE_TYPE;
  logic       CMD_REJECT;
  logic       TIMEOUT_PULSE;

  modport slave (
    input  CMD_VALID, CONTINUOUS_EN, BREAK_CONTINUOUS, DATA_TYPE,
    input  SENSOR_DONE, SENSOR_ERROR, TX_DONE,
    output SENSOR_START, TX_START, TX_TYPE, TX_ERR,
    output BUSY, CONT_ACTIVE, ACTIVE_TYPE, CMD_REJECT, TIMEOUT_PULSE
  );

  modport master (
    output CMD_VALID, CONTINUOUS_EN, BREAK_CONTINUOUS, DATA_TYPE,
    output SENSOR_DONE, SENSOR_ERROR, TX_DONE,
    input  SENSOR_START, TX_START, TX_TYPE, TX_ERR,
    input  BUSY, CONT_ACTIVE, ACTIVE_TYPE, CMD_REJECT, TIMEOUT_PULSE
  );
endinterface

// File: rtl/continuous_sensing_scheduler.sv
// Sequences single-shot and periodic sensor reads and their UART replies,
// including timeout handling and deferred stop of continuous mode.
module continuous_sensing_scheduler #(
  parameter int unsigned INTERVAL_CYCLES = 50000000,
  parameter int unsigned SENSOR_TIMEOUT  = 5000000,
  parameter int unsigned CNT_W           = 26
) (
  input  logic                         CLK,
  input  logic                         RST,
  continuous_sensing_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_SENSOR, S_SEND, S_WAIT_TX, S_INTERVAL
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cont_q, cont_d;
  logic [1:0]       type_q, type_d;
  logic [1:0]       tx_type_q, tx_type_d;
  logic             tx_err_q, tx_err_d;
  logic             stop_q, stop_d;
  logic             sensor_start_q, sensor_start_d;
  logic             tx_start_q, tx_start_d;
  logic             reject_q, reject_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;
  logic             brk_ok, go_idle, go_send;

  // A break is honoured only once, and only for the job type that is running.
  assign brk_ok = bus.CMD_VALID && bus.BREAK_CONTINUOUS && cont_q &&
                  (bus.DATA_TYPE == type_q) && !stop_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    cont_d         = cont_q;
    type_d         = type_q;
    tx_type_d      = tx_type_q;
    tx_err_d       = tx_err_q;
    stop_d         = stop_q;
    sensor_start_d = 1'b0;
    tx_start_d     = 1'b0;
    reject_d       = 1'b0;
    timeout_d      = 1'b0;
    go_idle        = 1'b0;
    go_send        = 1'b0;

    if (state_q != S_IDLE && bus.CMD_VALID) begin
      if (brk_ok) stop_d = 1'b1;
      else        reject_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.CMD_VALID) begin
          if (bus.DATA_TYPE == 2'b00 || bus.BREAK_CONTINUOUS) begin
            reject_d = 1'b1;
          end else begin
            type_d         = bus.DATA_TYPE;
            cont_d         = bus.CONTINUOUS_EN;
            state_d        = S_START;
            sensor_start_d = 1'b1;
          end
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT_SENSOR;
      end
      S_WAIT_SENSOR: begin
        if (bus.SENSOR_DONE) begin
          tx_err_d = bus.SENSOR_ERROR;
          go_send  = 1'b1;
        end else if (cnt_q == CNT_W'(SENSOR_TIMEOUT - 1)) begin
          tx_err_d  = 1'b1;
          timeout_d = 1'b1;
          go_send   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SEND: begin
        state_d = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (bus.TX_DONE) begin
          if (cont_q && !stop_q && !brk_ok) begin
            state_d = S_INTERVAL;
            cnt_d   = '0;
          end else begin
            go_idle = 1'b1;
          end
        end
      end
      S_INTERVAL: begin
        if (brk_ok) begin
          go_idle = 1'b1;
        end else if (cnt_q == CNT_W'(INTERVAL_CYCLES - 1)) begin
          state_d        = S_START;
          sensor_start_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: go_idle = 1'b1;
    endcase

    if (go_send) begin
      state_d    = S_SEND;
      tx_start_d = 1'b1;
      tx_type_d  = type_q;
    end

    // Returning to IDLE drops every piece of job context.
    if (go_idle) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      cont_d    = 1'b0;
      type_d    = 2'b00;
      tx_type_d = 2'b00;
      tx_err_d  = 1'b0;
      stop_d    = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      cont_q         <= 1'b0;
      type_q         <= 2'b00;
      tx_type_q      <= 2'b00;
      tx_err_q       <= 1'b0;
      stop_q         <= 1'b0;
      sensor_start_q <= 1'b0;
      tx_start_q     <= 1'b0;
      reject_q       <= 1'b0;
      timeout_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cont_q         <= cont_d;
      type_q         <= type_d;
      tx_type_q      <= tx_type_d;
      tx_err_q       <= tx_err_d;
      stop_q         <= stop_d;
      sensor_start_q <= sensor_start_d;
      tx_start_q     <= tx_start_d;
      reject_q       <= reject_d;
      timeout_q      <= timeout_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.SENSOR_START  = sensor_start_q;
  assign bus.TX_START      = tx_start_q;
  assign bus.TX_TYPE       = tx_type_q;
  assign bus.TX_ERR        = tx_err_q;
  assign bus.BUSY          = busy_q;
  assign bus.CONT_ACTIVE   = cont_q;
  assign bus.ACTIVE_TYPE   = type_q;
  assign bus.CMD_REJECT    = reject_q;
  assign bus.TIMEOUT_PULSE = timeout_q;

endmodule
